sha2_round_datapath: RTL and testbench

Parametrised SHA-2 compression datapath: the successor to the single-block SHA-256 working-register/feed-forward datapath. It adds a configurable word width and round count, so one design covers SHA-224/256 and SHA-384/512. It also adds an internal round counter and FSM, multi-block chaining, and a valid/ready digest output. It sits between the message-schedule/T1-T2 logic, which consumes `state_out` and `round_idx`, and the host-facing wrapper, which supplies IV and block framing.

---
 rtl/sha2_round_datapath.sv | 151 +++++++++++++++
 tb/tb_sha2_round_datapath.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_round_datapath.sv
`default_nettype none
// ============================================================================
// Module   : sha2_round_datapath
// Brief    : SHA-2 compression datapath with working/chaining registers,
//            round-counter FSM, feed-forward and valid/ready digest output.
// Revision : 1.0 - initial release
// ============================================================================
module sha2_round_datapath #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      first_blk,
    input  logic                      last_blk,
    input  logic [8*WORD_W-1:0]       iv,
    input  logic [WORD_W-1:0]         t1,
    input  logic [WORD_W-1:0]         t2,
    input  logic                      round_valid,
    output logic [8*WORD_W-1:0]       state_out,
    output logic [$clog2(ROUNDS)-1:0] round_idx,
    output logic                      busy,
    output logic                      block_done,
    output logic [8*WORD_W-1:0]       digest,
    output logic                      digest_valid,
    input  logic                      digest_ready
);

    localparam int                 c_IDX_W    = $clog2(ROUNDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(ROUNDS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ROUND = 2'd1;
    localparam logic [1:0] c_S_FINAL = 2'd2;
    localparam logic [1:0] c_S_HOLD  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WORD_W-1:0]  r_work  [8];
    logic [WORD_W-1:0]  r_chain [8];
    logic [WORD_W-1:0]  w_iv_word [8];
    logic [c_IDX_W-1:0] r_round_idx;
    logic               r_last;
    logic               r_busy;
    logic               r_block_done;
    logic               r_digest_valid;
    logic               w_busy_nxt;
    logic               w_block_done_nxt;
    logic               w_digest_valid_nxt;
    logic               w_start_acc;
    logic               w_round_acc;
    logic               w_round_end;

    // Word 0 (A / H0) occupies the most significant slice of every bus.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_word
            assign w_iv_word[gi]                          = iv[(7-gi)*WORD_W +: WORD_W];
            assign state_out[(7-gi)*WORD_W +: WORD_W]     = r_work[gi];
            assign digest[(7-gi)*WORD_W +: WORD_W]        = r_chain[gi];
        end
    endgenerate

    assign w_start_acc = (r_state == c_S_IDLE) && start;
    assign w_round_acc = (r_state == c_S_ROUND) && round_valid;
    assign w_round_end = w_round_acc && (r_round_idx == c_LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (start)        w_state_nxt = c_S_ROUND;
            c_S_ROUND: if (w_round_end)  w_state_nxt = c_S_FINAL;
            c_S_FINAL: w_state_nxt = r_last ? c_S_HOLD : c_S_IDLE;
            c_S_HOLD:  if (digest_ready) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they appear registered.
    always_comb begin
        w_busy_nxt         = (w_state_nxt != c_S_IDLE);
        w_block_done_nxt   = (w_state_nxt == c_S_FINAL);
        w_digest_valid_nxt = (w_state_nxt == c_S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy         <= 1'b0;
            r_block_done   <= 1'b0;
            r_digest_valid <= 1'b0;
        end else begin
            r_busy         <= w_busy_nxt;
            r_block_done   <= w_block_done_nxt;
            r_digest_valid <= w_digest_valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_work[i]  <= '0;
                r_chain[i] <= '0;
            end
            r_round_idx <= '0;
            r_last      <= 1'b0;
        end else if (w_start_acc) begin
            r_last      <= last_blk;
            r_round_idx <= '0;
            for (int i = 0; i < 8; i++) begin
                if (first_blk) begin
                    r_work[i]  <= w_iv_word[i];
                    r_chain[i] <= w_iv_word[i];
                end else begin
                    r_work[i]  <= r_chain[i];
                end
            end
        end else if (w_round_acc) begin
            r_work[0] <= t1 + t2;
            r_work[1] <= r_work[0];
            r_work[2] <= r_work[1];
            r_work[3] <= r_work[2];
            r_work[4] <= r_work[3] + t1;
            r_work[5] <= r_work[4];
            r_work[6] <= r_work[5];
            r_work[7] <= r_work[6];
            // Wrap to zero so the index never leaves 0..ROUNDS-1 for non-power-of-2 ROUNDS.
            r_round_idx <= w_round_end ? '0 : r_round_idx + c_IDX_ONE;
        end else if (r_state == c_S_FINAL) begin
            for (int i = 0; i < 8; i++) begin
                r_chain[i] <= r_chain[i] + r_work[i];
            end
        end
    end

    assign round_idx    = r_round_idx;
    assign busy         = r_busy;
    assign block_done   = r_block_done;
    assign digest_valid = r_digest_valid;

endmodule
`default_nettype wire

// File: tb/tb_sha2_round_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_round_datapath
// Brief    : Self-checking bench; SHA-256/512 reference model drives t1/t2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_round_datapath;

    localparam logic [31:0] c_K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [63:0] c_K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    localparam logic [255:0] c_IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] c_IV512 =
        {256'h6a09e667f3bcc908bb67ae8584caa73b3c6ef372fe94f82ba54ff53a5f1d36f1,
         256'h510e527fade682d19b05688c2b3e6c1f1f83d9abfb41bd6b5be0cd19137e2179};
    localparam logic [255:0] c_ABC256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_TWO256 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] c_ABC512 =
        {256'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a,
         256'h2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f};

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    logic rst;

    logic         start32, first32, last32, rv32, ready32;
    logic [255:0] iv32, so32, dg32;
    logic [31:0]  t1_32, t2_32;
    logic [5:0]   idx32;
    logic         busy32, bd32, dv32;

    logic         start64, first64, last64, rv64, ready64;
    logic [511:0] iv64, so64, dg64;
    logic [63:0]  t1_64, t2_64;
    logic [6:0]   idx64;
    logic         busy64, bd64, dv64;

    logic [0:7][31:0] h32;

    always #5 clk = ~clk;

    sha2_round_datapath dut32 (
        .clk(clk), .rst(rst), .start(start32), .first_blk(first32), .last_blk(last32),
        .iv(iv32), .t1(t1_32), .t2(t2_32), .round_valid(rv32), .state_out(so32),
        .round_idx(idx32), .busy(busy32), .block_done(bd32), .digest(dg32),
        .digest_valid(dv32), .digest_ready(ready32));

    sha2_round_datapath #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .first_blk(first64), .last_blk(last64),
        .iv(iv64), .t1(t1_64), .t2(t2_64), .round_valid(rv64), .state_out(so64),
        .round_idx(idx64), .busy(busy64), .block_done(bd64), .digest(dg64),
        .digest_valid(dv64), .digest_ready(ready64));

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic sha256_block(input logic [511:0] blk, input bit first, input bit last,
                                input logic [255:0] ivv, input int stall_pct,
                                input int ready_wait, input bit poke, input int abort_at);
        logic [31:0]      w [64];
        logic [0:7][31:0] v;
        logic [31:0]      x1, x2, s0, s1;
        int               r, spins;
        bit               vld;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr32(w[i-15], 7) ^ rotr32(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr32(w[i-2], 17) ^ rotr32(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        if (first) h32 = ivv;
        v = h32;
        start32 = 1'b1; first32 = first; last32 = last;
        iv32 = first ? ivv : rnd256();
        @(negedge clk);
        start32 = 1'b0; first32 = 1'b0;
        n_tests++;
        if (so32 !== v) begin n_fail++; $error("FAIL load_state: observed %0h expected %0h", so32, v); end
        n_tests++;
        if (idx32 !== 6'd0) begin n_fail++; $error("FAIL load_idx: observed %0h expected 0", idx32); end
        n_tests++;
        if ({busy32, bd32, dv32} !== 3'b100) begin n_fail++; $error("FAIL load_flags: observed %0b expected 100", {busy32, bd32, dv32}); end
        r = 0;
        spins = 0;
        while (r < 64) begin
            vld = (spins > 400) || ($urandom_range(99) >= stall_pct);
            spins++;
            x1 = v[7] + (rotr32(v[4], 6) ^ rotr32(v[4], 11) ^ rotr32(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + c_K256[r] + w[r];
            x2 = (rotr32(v[0], 2) ^ rotr32(v[0], 13) ^ rotr32(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            rv32  = vld;
            t1_32 = vld ? x1 : $urandom;
            t2_32 = vld ? x2 : $urandom;
            if (poke && r == 10) begin
                start32 = 1'b1; first32 = 1'b1; iv32 = rnd256();
            end
            @(negedge clk);
            start32 = 1'b0; first32 = 1'b0; rv32 = 1'b0;
            if (vld) begin
                v = {x1 + x2, v[0], v[1], v[2], v[3] + x1, v[4], v[5], v[6]};
                r++;
            end
            n_tests++;
            if (so32 !== v) begin n_fail++; $error("FAIL round_state: observed %0h expected %0h", so32, v); end
            if (r < 64) begin
                n_tests++;
                if (idx32 !== 6'(r)) begin n_fail++; $error("FAIL round_idx: observed %0h expected %0h", idx32, r); end
                n_tests++;
                if ({busy32, bd32, dv32} !== 3'b100) begin n_fail++; $error("FAIL round_flags: observed %0b expected 100", {busy32, bd32, dv32}); end
                if (r == abort_at) begin
                    rst = 1'b1;
                    #1;
                    n_tests++;
                    if (so32 !== 256'd0) begin n_fail++; $error("FAIL abort_state: observed %0h expected 0", so32); end
                    n_tests++;
                    if (idx32 !== 6'd0) begin n_fail++; $error("FAIL abort_idx: observed %0h expected 0", idx32); end
                    n_tests++;
                    if ({busy32, bd32, dv32} !== 3'b000) begin n_fail++; $error("FAIL abort_flags: observed %0b expected 000", {busy32, bd32, dv32}); end
                    n_tests++;
                    if (dg32 !== 256'd0) begin n_fail++; $error("FAIL abort_digest: observed %0h expected 0", dg32); end
                    @(negedge clk);
                    rst = 1'b0;
                    h32 = '0;
                    return;
                end
            end
        end
        n_tests++;
        if ({busy32, bd32, dv32} !== 3'b110) begin n_fail++; $error("FAIL final_flags: observed %0b expected 110", {busy32, bd32, dv32}); end
        for (int i = 0; i < 8; i++) h32[i] = h32[i] + v[i];
        @(negedge clk);
        if (last) begin
            n_tests++;
            if ({busy32, bd32, dv32} !== 3'b101) begin n_fail++; $error("FAIL hold_flags: observed %0b expected 101", {busy32, bd32, dv32}); end
            n_tests++;
            if (dg32 !== h32) begin n_fail++; $error("FAIL hold_digest: observed %0h expected %0h", dg32, h32); end
            for (int k = 0; k < ready_wait; k++) begin
                if (k == 1) begin
                    start32 = 1'b1; first32 = 1'b1; iv32 = rnd256();
                end
                @(negedge clk);
                start32 = 1'b0; first32 = 1'b0;
                n_tests++;
                if ({busy32, bd32, dv32} !== 3'b101) begin n_fail++; $error("FAIL bp_flags: observed %0b expected 101", {busy32, bd32, dv32}); end
                n_tests++;
                if (dg32 !== h32) begin n_fail++; $error("FAIL bp_digest: observed %0h expected %0h", dg32, h32); end
            end
            ready32 = 1'b1;
            @(negedge clk);
            ready32 = 1'b0;
            n_tests++;
            if ({busy32, bd32, dv32} !== 3'b000) begin n_fail++; $error("FAIL hs_flags: observed %0b expected 000", {busy32, bd32, dv32}); end
            n_tests++;
            if (dg32 !== h32) begin n_fail++; $error("FAIL hs_digest: observed %0h expected %0h", dg32, h32); end
        end else begin
            n_tests++;
            if ({busy32, bd32, dv32} !== 3'b000) begin n_fail++; $error("FAIL chain_flags: observed %0b expected 000", {busy32, bd32, dv32}); end
            n_tests++;
            if (dg32 !== h32) begin n_fail++; $error("FAIL chain_digest: observed %0h expected %0h", dg32, h32); end
        end
    endtask

    task automatic sha512_block(input logic [1023:0] blk);
        logic [63:0]      w [80];
        logic [0:7][63:0] v, h;
        logic [63:0]      x1, x2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[1023-64*i -: 64];
        for (int i = 16; i < 80; i++) begin
            s0 = rotr64(w[i-15], 1) ^ rotr64(w[i-15], 8) ^ (w[i-15] >> 7);
            s1 = rotr64(w[i-2], 19) ^ rotr64(w[i-2], 61) ^ (w[i-2] >> 6);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        h = c_IV512;
        v = h;
        start64 = 1'b1; first64 = 1'b1; last64 = 1'b1; iv64 = c_IV512;
        @(negedge clk);
        start64 = 1'b0; first64 = 1'b0;
        n_tests++;
        if (so64 !== v) begin n_fail++; $error("FAIL s512_load: observed %0h expected %0h", so64, v); end
        for (int r = 0; r < 80; r++) begin
            x1 = v[7] + (rotr64(v[4], 14) ^ rotr64(v[4], 18) ^ rotr64(v[4], 41))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + c_K512[r] + w[r];
            x2 = (rotr64(v[0], 28) ^ rotr64(v[0], 34) ^ rotr64(v[0], 39))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            rv64 = 1'b1; t1_64 = x1; t2_64 = x2;
            n_tests++;
            if (idx64 !== 7'(r)) begin n_fail++; $error("FAIL s512_idx: observed %0h expected %0h", idx64, r); end
            @(negedge clk);
            rv64 = 1'b0;
            v = {x1 + x2, v[0], v[1], v[2], v[3] + x1, v[4], v[5], v[6]};
            n_tests++;
            if (so64 !== v) begin n_fail++; $error("FAIL s512_state: observed %0h expected %0h", so64, v); end
        end
        n_tests++;
        if ({busy64, bd64, dv64} !== 3'b110) begin n_fail++; $error("FAIL s512_final: observed %0b expected 110", {busy64, bd64, dv64}); end
        for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        @(negedge clk);
        n_tests++;
        if ({busy64, bd64, dv64} !== 3'b101) begin n_fail++; $error("FAIL s512_hold: observed %0b expected 101", {busy64, bd64, dv64}); end
        n_tests++;
        if (dg64 !== h) begin n_fail++; $error("FAIL s512_digest: observed %0h expected %0h", dg64, h); end
        ready64 = 1'b1;
        @(negedge clk);
        ready64 = 1'b0;
        n_tests++;
        if ({busy64, bd64, dv64} !== 3'b000) begin n_fail++; $error("FAIL s512_idle: observed %0b expected 000", {busy64, bd64, dv64}); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0]  abc256, blk1, blk2, rblk;
        logic [1023:0] abc512;
        logic [447:0]  msg;
        abc256 = '0;
        abc256[511 -: 32] = 32'h61626380;
        abc256[63:0] = 64'd24;
        msg  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        blk1 = {msg, 8'h80, 56'd0};
        blk2 = {448'd0, 64'd448};
        abc512 = '0;
        abc512[1023 -: 32] = 32'h61626380;
        abc512[127:0] = 128'd24;

        rst = 1'b1;
        start32 = 0; first32 = 0; last32 = 0; rv32 = 0; ready32 = 0;
        iv32 = '0; t1_32 = '0; t2_32 = '0;
        start64 = 0; first64 = 0; last64 = 0; rv64 = 0; ready64 = 0;
        iv64 = '0; t1_64 = '0; t2_64 = '0;
        h32 = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (so32 !== 256'd0) begin n_fail++; $error("FAIL rst_state: observed %0h expected 0", so32); end
        n_tests++;
        if (idx32 !== 6'd0) begin n_fail++; $error("FAIL rst_idx: observed %0h expected 0", idx32); end
        n_tests++;
        if ({busy32, bd32, dv32} !== 3'b000) begin n_fail++; $error("FAIL rst_flags: observed %0b expected 000", {busy32, bd32, dv32}); end
        n_tests++;
        if (dg32 !== 256'd0) begin n_fail++; $error("FAIL rst_digest: observed %0h expected 0", dg32); end
        n_tests++;
        if ({busy64, bd64, dv64} !== 3'b000) begin n_fail++; $error("FAIL rst_flags64: observed %0b expected 000", {busy64, bd64, dv64}); end
        rst = 1'b0;

        rv32 = 1'b1; t1_32 = $urandom; t2_32 = $urandom;
        @(negedge clk);
        rv32 = 1'b0;
        n_tests++;
        if (so32 !== 256'd0) begin n_fail++; $error("FAIL idle_rv_state: observed %0h expected 0", so32); end
        n_tests++;
        if (idx32 !== 6'd0) begin n_fail++; $error("FAIL idle_rv_idx: observed %0h expected 0", idx32); end

        sha256_block(abc256, 1'b1, 1'b1, c_IV256, 0, 0, 1'b0, -1);
        n_tests++;
        if (dg32 !== c_ABC256) begin n_fail++; $error("FAIL abc256_digest: observed %0h expected %0h", dg32, c_ABC256); end

        sha256_block(blk1, 1'b1, 1'b0, c_IV256, 0, 0, 1'b0, -1);
        sha256_block(blk2, 1'b0, 1'b1, c_IV256, 0, 0, 1'b0, -1);
        n_tests++;
        if (dg32 !== c_TWO256) begin n_fail++; $error("FAIL two_block_digest: observed %0h expected %0h", dg32, c_TWO256); end

        sha256_block(abc256, 1'b1, 1'b1, c_IV256, 40, 5, 1'b1, -1);
        n_tests++;
        if (dg32 !== c_ABC256) begin n_fail++; $error("FAIL stall_abc_digest: observed %0h expected %0h", dg32, c_ABC256); end

        sha256_block(abc256, 1'b1, 1'b1, c_IV256, 0, 0, 1'b0, 30);
        sha256_block(abc256, 1'b0, 1'b1, c_IV256, 0, 0, 1'b0, -1);
        sha256_block(abc256, 1'b1, 1'b1, c_IV256, 0, 0, 1'b0, -1);
        n_tests++;
        if (dg32 !== c_ABC256) begin n_fail++; $error("FAIL post_rst_abc_digest: observed %0h expected %0h", dg32, c_ABC256); end

        for (int n = 0; n < 3; n++) begin
            rblk = {rnd256(), rnd256()};
            sha256_block(rblk, 1'b1, 1'b0, rnd256(), $urandom_range(50), 0, 1'b0, -1);
            rblk = {rnd256(), rnd256()};
            sha256_block(rblk, 1'b0, 1'b1, c_IV256, $urandom_range(50),
                         $urandom_range(4), 1'b1, -1);
        end

        sha512_block(abc512);
        n_tests++;
        if (dg64 !== c_ABC512) begin n_fail++; $error("FAIL abc512_digest: observed %0h expected %0h", dg64, c_ABC512); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
